// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: session sequencer for the timed-challenge mode.
// Runs ROUNDS answer rounds, each bounded by the shared countdown timer,
// scores each verdict, holds every round result for RESULT_HOLD cycles and
// reports session completion with a latched pass flag.
//
// Build option: define SPEED_BONUS_EN to award 2 points for a correct
// answer given while time_left >= 7. Without it every correct answer
// scores 1 and time_left is not used.
//
// Answer handshake: an answer is consumed on any clock edge where
// ans_valid && ans_ready are both high. ans_ready is high only during RUN,
// so ans_valid outside RUN is simply dropped; ans_correct is only looked at
// on that consuming edge. timer_done has no ready: it only acts in RUN, and
// a same-edge answer takes precedence over it.
`timescale 1ns/1ps

module quiz_round_ctrl #(
    parameter int ROUNDS      = 5,
    parameter int PASS_SCORE  = 3,
    parameter int RESULT_HOLD = 200_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       ans_valid,
    input  logic       ans_correct,
    input  logic [3:0] time_left,
    input  logic       timer_done,
    output logic       start_timer,
    output logic       ans_ready,
    output logic [3:0] round_idx,
    output logic [4:0] score,
    output logic [1:0] round_result,
    output logic       result_valid,
    output logic       session_busy,
    output logic       session_done,
    output logic       session_pass,
    output logic [1:0] state_dbg
);

    // Session states; the 2-bit encoding is exposed on state_dbg.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Round result codes shown on round_result.
    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_CORRECT = 2'b01;
    localparam logic [1:0] RES_WRONG   = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    localparam int              CNT_W      = $clog2(RESULT_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESULT_HOLD - 1);
    localparam logic [3:0]      LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [4:0]      PASS_THR   = 5'(PASS_SCORE);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;

    // Next values of the registered outputs.
    logic       start_timer_d;
    logic       ans_ready_d;
    logic [3:0] round_idx_d;
    logic [4:0] score_d;
    logic [1:0] round_result_d;
    logic       result_valid_d;
    logic       session_busy_d;
    logic       session_done_d;
    logic       session_pass_d;

    // Points awarded for a correct answer.
    logic [4:0] correct_inc;

    logic hold_last;
    logic more_rounds;
    logic abort_hit;

    assign hold_last   = (hold_cnt_q == HOLD_LAST);
    assign more_rounds = (round_idx < LAST_ROUND);
    // Abort is a no-op in IDLE apart from blocking a same-cycle start.
    assign abort_hit   = abort && (state_q != S_IDLE);
    assign state_dbg   = state_q;

`ifdef SPEED_BONUS_EN
    // Fast correct answers (7 s or more remaining) earn a double point.
    always_comb begin
        correct_inc = (time_left >= 4'd7) ? 5'd2 : 5'd1;
    end
`else
    // Flat scoring; time_left is folded into a sink so it stays connected.
    logic unused_time_left;
    assign unused_time_left = ^time_left;
    assign correct_inc      = 5'd1;
`endif

    // State, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            start_timer  <= 1'b0;
            ans_ready    <= 1'b0;
            round_idx    <= 4'd0;
            score        <= 5'd0;
            round_result <= RES_NONE;
            result_valid <= 1'b0;
            session_busy <= 1'b0;
            session_done <= 1'b0;
            session_pass <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            start_timer  <= start_timer_d;
            ans_ready    <= ans_ready_d;
            round_idx    <= round_idx_d;
            score        <= score_d;
            round_result <= round_result_d;
            result_valid <= result_valid_d;
            session_busy <= session_busy_d;
            session_done <= session_done_d;
            session_pass <= session_pass_d;
        end
    end

    // Next-state selection; abort outranks every other input.
    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (ans_valid || timer_done) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_last) begin
                        state_d = more_rounds ? S_RUN : S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Next output values and hold counter; registered values hold by default.
    always_comb begin
        hold_cnt_d     = hold_cnt_q;
        start_timer_d  = start_timer;
        ans_ready_d    = ans_ready;
        round_idx_d    = round_idx;
        score_d        = score;
        round_result_d = round_result;
        result_valid_d = 1'b0;
        session_busy_d = session_busy;
        session_done_d = 1'b0;
        session_pass_d = session_pass;

        if (abort_hit) begin
            // Cancel: timer released, scoring cleared, no completion pulse.
            hold_cnt_d     = '0;
            start_timer_d  = 1'b0;
            ans_ready_d    = 1'b0;
            score_d        = 5'd0;
            round_result_d = RES_NONE;
            session_busy_d = 1'b0;
            session_pass_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        hold_cnt_d     = '0;
                        start_timer_d  = 1'b1;
                        ans_ready_d    = 1'b1;
                        round_idx_d    = 4'd0;
                        score_d        = 5'd0;
                        round_result_d = RES_NONE;
                        session_busy_d = 1'b1;
                        session_pass_d = 1'b0;
                    end
                end
                S_RUN: begin
                    if (ans_valid) begin
                        // The answer wins over a same-cycle timer expiry.
                        hold_cnt_d     = '0;
                        start_timer_d  = 1'b0;
                        ans_ready_d    = 1'b0;
                        result_valid_d = 1'b1;
                        if (ans_correct) begin
                            round_result_d = RES_CORRECT;
                            score_d        = score + correct_inc;
                        end else begin
                            round_result_d = RES_WRONG;
                        end
                    end else if (timer_done) begin
                        hold_cnt_d     = '0;
                        start_timer_d  = 1'b0;
                        ans_ready_d    = 1'b0;
                        result_valid_d = 1'b1;
                        round_result_d = RES_TIMEOUT;
                    end
                end
                S_HOLD: begin
                    // Timer stays released for the whole hold so it reloads.
                    if (hold_last) begin
                        hold_cnt_d = '0;
                        if (more_rounds) begin
                            start_timer_d  = 1'b1;
                            ans_ready_d    = 1'b1;
                            round_idx_d    = round_idx + 4'd1;
                            round_result_d = RES_NONE;
                        end else begin
                            session_done_d = 1'b1;
                            session_busy_d = 1'b0;
                            session_pass_d = (score >= PASS_THR);
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Final score, round and pass flag stay visible in IDLE.
                    hold_cnt_d = '0;
                end
                default: begin
                    hold_cnt_d     = '0;
                    start_timer_d  = 1'b0;
                    ans_ready_d    = 1'b0;
                    round_idx_d    = 4'd0;
                    score_d        = 5'd0;
                    round_result_d = RES_NONE;
                    session_busy_d = 1'b0;
                    session_pass_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Session sequencer for the CalcKit timed-challenge mode.
- Runs ROUNDS consecutive answer rounds. Each round is bounded by the shared 10 s countdown timer, which this block drives through its level-sensitive start_timer input.
- Accepts answer verdicts from the calculator core, scores them and holds each round's result for display.
- Reports session completion and pass/fail to the top-level display/LED logic.

Parameters:
- ROUNDS, 5, rounds per session (1-15).
- PASS_SCORE, 3, minimum final score for session_pass.
- RESULT_HOLD, 200_000_000, cycles each round result is held before the next round (2 s at 100 MHz; must be >= 2).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  session start request; sampled only in IDLE.
- abort  in  1  cancel session; sampled in any state.
- ans_valid  in  1  answer submitted this cycle.
- ans_correct  in  1  verdict qualifying ans_valid.
- time_left  in  4  countdown value from the timer (0-10).
- timer_done  in  1  one-cycle timer expiry pulse.
- start_timer  out  1  level; high keeps the timer counting, low returns it to idle.
- ans_ready  out  1  high only when an answer is accepted (RUN).
- round_idx  out  4  current round, 0-based.
- score  out  5  accumulated score.
- round_result  out  2  00 none, 01 correct, 10 wrong, 11 timeout.
- result_valid  out  1  one-cycle pulse when round_result is updated.
- session_busy  out  1  high in RUN and HOLD.
- session_done  out  1  one-cycle pulse at session end.
- session_pass  out  1  latched pass flag; valid from session_done until the next start or reset.

Behaviour:
- All outputs are registered.
- Reset values (rst high at a clock edge): state IDLE; all outputs 0.
- States: IDLE, RUN, HOLD, DONE. Encodings outside these states return to IDLE.
- IDLE:
  - start=1 -> next cycle: RUN, start_timer=1, ans_ready=1, session_busy=1, round_idx=0, score=0, round_result=00, session_pass=0.
  - start=0 -> remain in IDLE.
- RUN (round in progress, start_timer held high):
  - ans_valid=1 -> next cycle: HOLD, start_timer=0, ans_ready=0, result_valid=1.
    - ans_correct=1 -> round_result=01, score+1.
    - ans_correct=0 -> round_result=10, score unchanged.
  - timer_done=1 with ans_valid=0 -> next cycle: HOLD, round_result=11, result_valid=1, score unchanged.
  - ans_valid and timer_done in the same cycle -> the answer wins; treat as answer only.
- HOLD:
  - start_timer stays low for the whole HOLD, so the timer fully returns to idle and reloads 10 before the next round.
  - Hold counter runs 0 .. RESULT_HOLD-1; round_result stays stable throughout.
  - ans_valid and timer_done are ignored.
  - At counter = RESULT_HOLD-1:
    - round_idx < ROUNDS-1 -> RUN, round_idx+1, round_result=00, start_timer=1, ans_ready=1.
    - otherwise -> DONE.
- DONE (one cycle):
  - session_done=1, session_pass = (score >= PASS_SCORE), session_busy=0.
  - Next cycle -> IDLE. score, round_idx and session_pass hold their values until the next start.
- Abort:
  - abort=1 in RUN, HOLD or DONE -> next cycle IDLE; start_timer=0, ans_ready=0, score=0, round_result=00, session_busy=0.
  - No session_done pulse; session_pass=0.
  - abort has priority over ans_valid, timer_done and start.
- start while session_busy is ignored.
- Reset mid-session behaves as abort plus clears all counters.
- Score width: 5 bits. The maximum score (2*ROUNDS with the bonus below) fits; no saturation is needed.

Optional Feature:
- Macro: SPEED_BONUS_EN.
- Defined: a correct answer accepted while time_left >= 7 adds 2 to score instead of 1; round_result is still 01.
- Undefined: every correct answer adds exactly 1; the time_left port is present but unused.

Test Plan:
Bench setup: ROUNDS=3, PASS_SCORE=2, RESULT_HOLD=4, timer driven by a behavioural model.
1. Reset, then start pulse -> next cycle RUN, start_timer=1, ans_ready=1, round_idx=0, score=0, all other outputs 0.
2. Three rounds, correct / wrong / correct -> round_result 01, 10, 01 with one result_valid pulse each; start_timer low for exactly 4 HOLD cycles between rounds; session_done pulse with score=2, session_pass=1.
3. Round 0 with timer_done only, rounds 1 and 2 wrong -> round_result=11 then 10, 10; final score=0, session_pass=0; timer reloaded to time_left=10 at the start of each round.
4. ans_valid=1, ans_correct=1 and timer_done=1 in the same cycle -> round_result=01, score=1, exactly one result_valid pulse.
5. abort during HOLD of round 1 -> next cycle IDLE, start_timer=0, score=0, no session_done; a start one cycle later begins a fresh session at round_idx=0.
6. SPEED_BONUS_EN defined: correct answer at time_left=8 -> score+2; correct answer at time_left=6 -> score+1. Undefined: both cases give score+1.
